// File: rtl/jt10_adpcmb_seq.sv
// jt10_adpcmb_seq: time-multiplexed ADPCM-B fetch sequencer.
// On every cen55 tick each channel in turn advances its delta-N phase
// accumulator, steps its nibble pointer, fetches a byte through a shared
// req/ack port when needed and emits one nibble record to the decoder.
// Optional feature: define JT10_ADPCMB_BYTECACHE_EN to keep a per-channel
// byte cache so the low-nibble step reuses the byte fetched for the high one.
module jt10_adpcmb_seq #(
    parameter  int CH  = 2,
    parameter  int AW  = 24,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen55,
    input  logic [CH-1:0]    on,
    input  logic [CH-1:0]    rep,
    input  logic [CH-1:0]    clr,
    input  logic [CH*16-1:0] astart,
    input  logic [CH*16-1:0] aend,
    input  logic [CH*16-1:0] deltan,
    input  logic [CH-1:0]    clr_flag,
    output logic [CH-1:0]    flag,
    output logic             ovr,
    output logic             busy,
    output logic             mem_req,
    output logic [AW-1:0]    mem_addr,
    input  logic             mem_ack,
    input  logic [7:0]       mem_data,
    output logic             nib_valid,
    output logic [CHW-1:0]   nib_ch,
    output logic             nib_on,
    output logic             nib_adv,
    output logic [3:0]       nib_data
);

    typedef enum logic [2:0] {IDLE, CALC, REQ, WAIT, EMIT} state_t;

    state_t         state, state_nx;
    logic [CHW-1:0] ch;

    // Per-channel playback state
    logic [AW-1:0]  ptr      [CH];
    logic [15:0]    acc      [CH];
    logic [3:0]     last_nib [CH];
    logic [CH-1:0]  lo;        // 1: current nibble is the low one
    logic [CH-1:0]  playing;
    logic [CH-1:0]  first;     // start byte not fetched yet
    logic [CH-1:0]  on_q;      // on[] as seen at the channel's previous slot
`ifdef JT10_ADPCMB_BYTECACHE_EN
    logic [7:0]     cbyte    [CH];
    logic [CH-1:0]  cvalid;
`endif

    // Record being assembled for the current slot
    logic           rec_on, rec_adv, rec_lo;
    logic [3:0]     rec_data;

    // Slot computation results for channel ch
    logic [AW-1:0]  start_b, end_b, c_ptr;
    logic [15:0]    c_acc;
    logic [16:0]    c_sum;
    logic [3:0]     c_nib;
    logic           c_lo, c_play, c_first, c_adv, c_fetch, c_flag, c_cinv, c_hit;
    logic           last_ch;

    assign last_ch  = (ch == CHW'(CH - 1));
    assign nib_ch   = ch;
    assign nib_on   = rec_on;
    assign nib_adv  = rec_adv;
    assign nib_data = rec_data;

    // Per-slot update: key-on/off, clr, accumulator step, nibble step, end handling
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        start_b = AW'(astart[16*int'(ch) +: 16]) << (AW - 16);
        end_b   = (AW'(aend[16*int'(ch) +: 16]) << (AW - 16))
                | ((AW'(1) << (AW - 16)) - AW'(1));
        c_ptr   = ptr[ch];
        c_acc   = acc[ch];
        c_lo    = lo[ch];
        c_play  = playing[ch];
        c_first = first[ch];
        c_adv   = 1'b0;
        c_fetch = 1'b0;
        c_flag  = 1'b0;
        c_cinv  = 1'b0;
        c_sum   = 17'd0;
        c_nib   = last_nib[ch];

        if (on[ch] && !on_q[ch]) begin
            c_ptr   = start_b;
            c_acc   = 16'd0;
            c_lo    = 1'b0;
            c_play  = 1'b1;
            c_first = 1'b1;
            c_cinv  = 1'b1;
        end else if (!on[ch]) begin
            c_play = 1'b0;
        end

        if (clr[ch]) begin
            c_ptr   = start_b;
            c_acc   = 16'd0;
            c_lo    = 1'b0;
            c_first = 1'b1;
            c_cinv  = 1'b1;
        end

`ifdef JT10_ADPCMB_BYTECACHE_EN
        c_hit = cvalid[ch] && !c_cinv;
`else
        c_hit = 1'b0;
`endif

        c_sum = {1'b0, c_acc} + {1'b0, deltan[16*int'(ch) +: 16]};
        if (c_play && !clr[ch]) begin
            c_acc = c_sum[15:0];
            c_adv = c_sum[16] | c_first;
        end

        if (c_adv) begin
            if (c_first) begin
                c_first = 1'b0;
                c_fetch = 1'b1;
            end else if (!c_lo) begin
                c_lo    = 1'b1;
                c_fetch = !c_hit;
            end else if (c_ptr == end_b) begin
                c_flag = 1'b1;
                if (rep[ch]) begin
                    c_ptr   = start_b;
                    c_lo    = 1'b0;
                    c_fetch = 1'b1;
                    c_cinv  = 1'b1;
                end else begin
                    c_play = 1'b0;
                    c_adv  = 1'b0;
                end
            end else begin
                c_ptr   = c_ptr + AW'(1);
                c_lo    = 1'b0;
                c_fetch = 1'b1;
            end
        end

`ifdef JT10_ADPCMB_BYTECACHE_EN
        if (c_adv && !c_fetch) c_nib = cbyte[ch][3:0];
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state and strobes
    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        mem_req   = (state == REQ) || (state == WAIT);
        nib_valid = (state == EMIT);
        case (state)
            IDLE:       if (cen55) state_nx = CALC;
            CALC:       state_nx = c_fetch ? REQ : EMIT;
            REQ, WAIT:  state_nx = mem_ack ? EMIT : WAIT;
            EMIT:       state_nx = last_ch ? IDLE : CALC;
            default:    state_nx = IDLE;
        endcase
    end

    // Channel datapath, record assembly, flags and overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-channel arrays are a handful of flops, so they are reset explicitly rather than left undefined.
            for (int i = 0; i < CH; i++) begin
                ptr[i]      <= '0;
                acc[i]      <= '0;
                last_nib[i] <= '0;
`ifdef JT10_ADPCMB_BYTECACHE_EN
                cbyte[i]    <= '0;
`endif
            end
`ifdef JT10_ADPCMB_BYTECACHE_EN
            cvalid   <= '0;
`endif
            lo       <= '0;
            playing  <= '0;
            first    <= '0;
            on_q     <= '0;
            flag     <= '0;
            ovr      <= 1'b0;
            ch       <= '0;
            mem_addr <= '0;
            rec_on   <= 1'b0;
            rec_adv  <= 1'b0;
            rec_lo   <= 1'b0;
            rec_data <= '0;
        end else begin
            if (cen55 && state != IDLE) ovr <= 1'b1;

            for (int i = 0; i < CH; i++) begin
                if (state == CALC && c_flag && ch == CHW'(i)) flag[i] <= 1'b1;
                else if (clr_flag[i])                        flag[i] <= 1'b0;
            end

            case (state)
                IDLE: if (cen55) ch <= '0;
                CALC: begin
                    ptr[ch]     <= c_ptr;
                    acc[ch]     <= c_acc;
                    lo[ch]      <= c_lo;
                    playing[ch] <= c_play;
                    first[ch]   <= c_first;
                    on_q[ch]    <= on[ch];
                    rec_on      <= c_play;
                    rec_adv     <= c_adv;
                    rec_lo      <= c_lo;
                    rec_data    <= c_nib;
                    if (c_fetch) mem_addr <= c_ptr;
`ifdef JT10_ADPCMB_BYTECACHE_EN
                    if (c_cinv) cvalid[ch] <= 1'b0;
`endif
                end
                REQ, WAIT: if (mem_ack) begin
                    rec_data <= rec_lo ? mem_data[3:0] : mem_data[7:4];
`ifdef JT10_ADPCMB_BYTECACHE_EN
                    cbyte[ch]  <= mem_data;
                    cvalid[ch] <= 1'b1;
`endif
                end
                EMIT: begin
                    last_nib[ch] <= rec_data;
                    if (!last_ch) ch <= ch + CHW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt10_adpcmb_seq.sv
// tb_jt10_adpcmb_seq: scoreboard bench for the ADPCM-B fetch sequencer.
// AW=17 keeps the start..end byte span short: astart=aend=0x0010 covers
// bytes 0x20..0x21, so the end and repeat paths are reached in a few ticks.
module tb_jt10_adpcmb_seq;
    localparam int CH = 2;
    localparam int AW = 17;
`ifdef JT10_ADPCMB_BYTECACHE_EN
    localparam int EXP_REQ4 = 2;
`else
    localparam int EXP_REQ4 = 4;
`endif

    typedef struct packed {
        logic       ch;
        logic       on;
        logic       adv;
        logic [3:0] data;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst, cen55;
    logic [CH-1:0]    on, rep, clr, clr_flag, flag;
    logic [CH*16-1:0] astart, aend, deltan;
    logic             ovr, busy, mem_req, mem_ack, nib_valid, nib_on, nib_adv;
    logic [AW-1:0]    mem_addr;
    logic [7:0]       mem_data;
    logic [0:0]       nib_ch;
    logic [3:0]       nib_data;

    int   vectors = 0, miscompares = 0;
    int   req_count = 0, nib_count = 0, ack_delay = 1;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_req = 1'b0;
    rec_t          exp_q [$];

    jt10_adpcmb_seq #(.CH(CH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cen55(cen55), .on(on), .rep(rep), .clr(clr),
        .astart(astart), .aend(aend), .deltan(deltan), .clr_flag(clr_flag),
        .flag(flag), .ovr(ovr), .busy(busy), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .nib_valid(nib_valid), .nib_ch(nib_ch), .nib_on(nib_on),
        .nib_adv(nib_adv), .nib_data(nib_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        case (a)
            17'h00020: return 8'hA5;
            17'h00021: return 8'h3C;
            17'h00080: return 8'h96;
            17'h00081: return 8'h7E;
            default:   return a[7:0];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic c, input logic o, input logic a, input logic [3:0] d);
        exp_q.push_back('{ch: c, on: o, adv: a, data: d});
    endtask

    // Monitor: pop an expected record on every strobe; watch address stability
    always @(negedge clk) begin
        if (nib_valid) begin
            nib_count++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_record: got ch%0d on=%0d adv=%0d nib=%0h, expected none",
                         nib_ch, nib_on, nib_adv, nib_data);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                check($sformatf("record_ch%0d", e.ch), 32'({nib_ch, nib_on, nib_adv, nib_data}), 32'(e));
            end
        end
        if (mem_req && prev_req) check("addr_stable", 32'(mem_addr), 32'(prev_addr));
        prev_req  = mem_req;
        prev_addr = mem_addr;
    end

    // Memory responder: ack_delay cycles after a request is seen, one-cycle ack
    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                req_count++;
                last_addr = mem_addr;
                repeat (ack_delay - 1) @(negedge clk);
                mem_ack  = 1'b1;
                mem_data = rom_byte(last_addr);
                @(negedge clk);
                mem_ack  = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    // One accepted tick; optionally pulse clr_flag in the channel-0 slot cycle
    task automatic tick(input logic pulse_clr);
        @(posedge clk); #1 cen55 = 1'b1;
        @(posedge clk); #1 cen55 = 1'b0; clr_flag = {1'b0, pulse_clr};
        @(posedge clk); #1 clr_flag = '0;
        wait_idle(400);
    endtask

    task automatic clear_flags();
        @(posedge clk); #1 clr_flag = '1;
        @(posedge clk); #1 clr_flag = '0;
        @(negedge clk);
        check("flag_cleared", 32'(flag), 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] t3_d0 [7] = '{4'hA, 4'h5, 4'h5, 4'h3, 4'h3, 4'hC, 4'hC};
        logic [3:0] t3_d1 [7] = '{4'h9, 4'h6, 4'h6, 4'h7, 4'h7, 4'hE, 4'hE};
        logic       t3_adv [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] t1_d [4]  = '{4'hA, 4'h5, 4'h3, 4'hC};
        int req0, nib0, n;

        rst = 1'b1; cen55 = 1'b0; on = '0; rep = '0; clr = '0; clr_flag = '0;
        astart = {16'h0040, 16'h0010};
        aend   = {16'h00FF, 16'h0010};
        deltan = {16'h0000, 16'hFFFF};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_flag", 32'(flag), 32'h0);
        check("reset_ovr", 32'(ovr), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_mem_req", 32'(mem_req), 32'h0);
        check("reset_mem_addr", 32'(mem_addr), 32'h0);
        check("reset_nib_valid", 32'(nib_valid), 32'h0);

        // deltan=0xFFFF, no repeat: A,5,3,C then end at low nibble of 0x21
        @(posedge clk); #1 on = 2'b01;
        req0 = req_count;
        for (int t = 0; t < 4; t++) begin
            push(1'b0, 1'b1, 1'b1, t1_d[t]);
            push(1'b1, 1'b0, 1'b0, 4'h0);
            tick(1'b0);
            if (t == 2) check("fetch_addr_next_byte", 32'(last_addr), 32'h21);
        end
        check("mem_req_count_4adv", 32'(req_count - req0), 32'(EXP_REQ4));
        push(1'b0, 1'b0, 1'b0, 4'hC); push(1'b1, 1'b0, 1'b0, 4'h0); tick(1'b0);
        check("end_flag_set", 32'(flag), 32'h1);
        push(1'b0, 1'b0, 1'b0, 4'hC); push(1'b1, 1'b0, 1'b0, 4'h0); tick(1'b0);

        // key off one tick, then repeat enabled: wrap back to 0x20 on end
        @(posedge clk); #1 on = 2'b00;
        push(1'b0, 1'b0, 1'b0, 4'hC); push(1'b1, 1'b0, 1'b0, 4'h0); tick(1'b0);
        @(posedge clk); #1 on = 2'b01; rep = 2'b01;
        clear_flags();
        for (int t = 0; t < 4; t++) begin
            push(1'b0, 1'b1, 1'b1, t1_d[t]);
            push(1'b1, 1'b0, 1'b0, 4'h0);
            tick(1'b0);
        end
        push(1'b0, 1'b1, 1'b1, 4'hA); push(1'b1, 1'b0, 1'b0, 4'h0);
        tick(1'b1);
        check("flag_set_wins_clr", 32'(flag), 32'h1);
        check("repeat_fetch_addr", 32'(last_addr), 32'h20);

        // deltan=0x8000 on both channels: advance every other tick
        @(posedge clk); #1 on = 2'b00;
        push(1'b0, 1'b0, 1'b0, 4'hA); push(1'b1, 1'b0, 1'b0, 4'h0); tick(1'b0);
        @(posedge clk); #1 on = 2'b11; deltan = {16'h8000, 16'h8000};
        for (int t = 0; t < 7; t++) begin
            push(1'b0, 1'b1, t3_adv[t], t3_d0[t]);
            push(1'b1, 1'b1, t3_adv[t], t3_d1[t]);
            nib0 = nib_count;
            tick(1'b0);
            check("records_per_tick", 32'(nib_count - nib0), 32'd2);
        end
        check("ovr_still_clear", 32'(ovr), 32'h0);
        clear_flags();

        // slow memory with a tick arriving mid-sequence: overrun, nothing lost
        ack_delay = 40;
        push(1'b0, 1'b1, 1'b1, 4'hA); push(1'b1, 1'b1, 1'b1, 4'h8);
        nib0 = nib_count;
        @(posedge clk); #1 cen55 = 1'b1;
        @(posedge clk); #1 cen55 = 1'b0;
        repeat (29) @(posedge clk);
        #1 cen55 = 1'b1;
        @(posedge clk); #1 cen55 = 1'b0;
        wait_idle(500);
        repeat (4) @(negedge clk);
        check("ovr_set", 32'(ovr), 32'h1);
        check("wrap_flag_ch0", 32'(flag), 32'h1);
        check("overrun_records", 32'(nib_count - nib0), 32'd2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // reset while a fetch is outstanding
        ack_delay = 2;
        @(posedge clk); #1 on = 2'b00;
        push(1'b0, 1'b0, 1'b0, 4'hA); push(1'b1, 1'b0, 1'b0, 4'h8); tick(1'b0);
        @(posedge clk); #1 on = 2'b01; ack_delay = 20;
        @(posedge clk); #1 cen55 = 1'b1;
        @(posedge clk); #1 cen55 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_req_seen", 32'(mem_req), 32'h1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_req", 32'(mem_req), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_flag", 32'(flag), 32'h0);
        check("rst_mid_ovr", 32'(ovr), 32'h0);
        nib0 = nib_count;
        repeat (40) @(negedge clk);
        check("late_ack_no_record", 32'(nib_count - nib0), 32'd0);
        check("late_ack_idle", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
